// File: rtl/store_data_align.sv
// -----------------------------------------------------------------------------
// store_data_align
//
// Store-side lane aligner. A store request from the core (byte address, rs2
// data, funct3) is turned into one or two word-aligned write beats for the data
// memory. Each beat has a word address, lane-positioned write data and a byte
// strobe. A halfword or word store that crosses a word boundary is split into
// two beats when SPLIT_MISALIGNED=1. When SPLIT_MISALIGNED=0 it is rejected
// with a one-cycle err pulse. Each beat is held under a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_valid   store request valid
//   req_ready   request accepted when req_valid && req_ready
//   req_addr    byte address
//   req_data    rs2 store data, LSB-justified
//   req_funct3  000 SB, 001 SH, 010 SW; other codes are illegal
//   mem_valid   write beat valid
//   mem_ready   memory accepts the beat when mem_valid && mem_ready
//   mem_addr    word-aligned beat address (bits [1:0] = 00)
//   mem_wdata   lane-positioned write data (unstrobed lanes are 0)
//   mem_wstrb   byte enables, bit i = byte lane i
//   busy        a beat is pending (state != IDLE)
//   err         one-cycle pulse after a rejected request
// -----------------------------------------------------------------------------
module store_data_align #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_funct3,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        err_q, err_d;

    // The second beat is computed and stored when the request is accepted, so
    // req_* may change freely while beat0 is still waiting for mem_ready.
    logic        need_beat1_q, need_beat1_d;
    logic [31:0] beat1_addr_q, beat1_addr_d;
    logic [31:0] beat1_wdata_q, beat1_wdata_d;
    logic [3:0]  beat1_wstrb_q, beat1_wstrb_d;

    // ------------------------------------------------------------------
    // Lane math for the incoming request
    // ------------------------------------------------------------------
    logic [3:0]  size_mask;
    logic        size_legal;
    logic [31:0] data_masked;
    logic [63:0] data_shifted;
    logic [7:0]  strb_shifted;
    logic        crosses_word;
    logic        req_legal;
    logic [31:0] beat0_addr;
    logic [31:0] next_word_addr;

    always_comb begin
        size_mask  = 4'h0;
        size_legal = 1'b0;
        case (req_funct3)
            3'b000: begin size_mask = 4'h1; size_legal = 1'b1; end
            3'b001: begin size_mask = 4'h3; size_legal = 1'b1; end
            3'b010: begin size_mask = 4'hF; size_legal = 1'b1; end
            default: begin size_mask = 4'h0; size_legal = 1'b0; end
        endcase
    end

    // Drop the bytes above the access size so that they cannot leak into
    // neighbouring lanes after the shift.
    for (genvar gi = 0; gi < 4; gi++) begin : g_size_mask
        assign data_masked[8*gi +: 8] = req_data[8*gi +: 8] & {8{size_mask[gi]}};
    end

    assign data_shifted   = {32'b0, data_masked} << {req_addr[1:0], 3'b000};
    assign strb_shifted   = {4'b0, size_mask} << req_addr[1:0];
    assign crosses_word   = |strb_shifted[7:4];
    assign req_legal      = size_legal && (SPLIT_MISALIGNED || !crosses_word);
    assign beat0_addr     = {req_addr[31:2], 2'b00};
    // The natural 32-bit wrap takes 0xFFFFFFFC to 0x00000000.
    assign next_word_addr = beat0_addr + 32'd4;

    // ------------------------------------------------------------------
    // Handshake and acceptance
    // ------------------------------------------------------------------
    logic mem_hs;
    logic final_beat;
    logic req_fire;

    assign mem_hs     = mem_valid_q && mem_ready;
    assign final_beat = (state_q == BEAT1) || ((state_q == BEAT0) && !need_beat1_q);
    // A new request can be taken in the same cycle as the last beat retires,
    // so back-to-back single-beat stores run at one beat per cycle.
    assign req_ready  = (state_q == IDLE) || (mem_hs && final_beat);
    assign req_fire   = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        err_d         = 1'b0;
        need_beat1_d  = need_beat1_q;
        beat1_addr_d  = beat1_addr_q;
        beat1_wdata_d = beat1_wdata_q;
        beat1_wstrb_d = beat1_wstrb_q;

        if (mem_hs) begin
            if ((state_q == BEAT0) && need_beat1_q) begin
                state_d      = BEAT1;
                mem_addr_d   = beat1_addr_q;
                mem_wdata_d  = beat1_wdata_q;
                mem_wstrb_d  = beat1_wstrb_q;
                need_beat1_d = 1'b0;
            end else begin
                // Last beat retired; a request accepted below overrides this.
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        end

        // req_fire only happens when idle or on the final-beat handshake,
        // so it never disturbs a beat that is still pending.
        if (req_fire) begin
            if (req_legal) begin
                state_d       = BEAT0;
                mem_valid_d   = 1'b1;
                mem_addr_d    = beat0_addr;
                mem_wdata_d   = data_shifted[31:0];
                mem_wstrb_d   = strb_shifted[3:0];
                need_beat1_d  = crosses_word;
                beat1_addr_d  = next_word_addr;
                beat1_wdata_d = data_shifted[63:32];
                beat1_wstrb_d = strb_shifted[7:4];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_wstrb_q   <= 4'h0;
            err_q         <= 1'b0;
            need_beat1_q  <= 1'b0;
            beat1_addr_q  <= 32'h0;
            beat1_wdata_q <= 32'h0;
            beat1_wstrb_q <= 4'h0;
        end else begin
            state_q       <= state_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            err_q         <= err_d;
            need_beat1_q  <= need_beat1_d;
            beat1_addr_q  <= beat1_addr_d;
            beat1_wdata_q <= beat1_wdata_d;
            beat1_wstrb_q <= beat1_wstrb_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/store_data_align.md
Name: store_data_align

Overview:
- Store-side counterpart of the load data extender. Takes a store request (address, rs2 data, funct3) from the core.
- Produces word-aligned write beats for the data memory: word address, lane-shifted write data and a 4-bit byte strobe.
- Splits misaligned halfword/word stores that cross a word boundary into two beats. Holds each beat under a valid/ready handshake until the memory accepts it.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = split boundary-crossing stores into two beats; 0 = reject them with err.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  store request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  32  byte address
- req_data  input  32  rs2 store data, LSB-justified
- req_funct3  input  3  000 SB, 001 SH, 010 SW; other codes illegal
- mem_valid  output  1  write beat valid
- mem_ready  input  1  memory accepts beat when mem_valid && mem_ready
- mem_addr  output  32  word-aligned address, bits [1:0] always 00
- mem_wdata  output  32  lane-positioned write data
- mem_wstrb  output  4  byte enables, bit i = byte lane i
- busy  output  1  state != IDLE
- err  output  1  one-cycle pulse on a rejected request

Behaviour:
- Reset values: state IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, err=0, busy=0. Reset also applies mid-transfer: the pending beat(s) are dropped, mem_valid=0 from the next cycle, and there is no err.
- FSM states: IDLE, BEAT0, BEAT1. All mem_* outputs and err are registered.
- Acceptance and latency:
  - req_ready = (state==IDLE) || (mem_valid && mem_ready && final beat).
  - A request accepted in cycle N drives mem_valid in cycle N+1.
  - Back-to-back single-beat stores therefore sustain 1 beat per cycle.
- Lane math, with o = req_addr[1:0]:
  - Size mask m: SB=0x1, SH=0x3, SW=0xF.
  - D64 = {32'b0, req_data masked to the size} << (8*o); S8 = m << o (8 bits).
  - Beat0: mem_addr = {req_addr[31:2], 2'b00}, wdata = D64[31:0], wstrb = S8[3:0].
  - Beat1 is needed iff S8[7:4] != 0: mem_addr = beat0 addr + 4 (wraps 0xFFFFFFFC -> 0x00000000), wdata = D64[63:32], wstrb = S8[7:4].
  - Lanes with strobe 0 carry 0.
- Transitions:
  - IDLE: on accept of a legal request go to BEAT0.
  - BEAT0: on handshake go to BEAT1 if a second beat is needed. Otherwise go to BEAT0 again if a new request is accepted in the same cycle, else IDLE.
  - BEAT1: on handshake go to BEAT0 if a new request is accepted in the same cycle, else IDLE.
- Stability: while mem_valid && !mem_ready, mem_addr, mem_wdata and mem_wstrb hold stable and mem_valid stays high.
- Request latching: all second-beat data is latched at acceptance; req_* may change after accept.
- Illegal funct3 (011, 1xx), or a boundary-crossing request with SPLIT_MISALIGNED=0:
  - The request is accepted (req_ready per the rule above) and err pulses in cycle N+1.
  - No beat is issued; the FSM goes to / stays in IDLE unless a prior beat is still pending.
- Simultaneous final-beat handshake and new request: the new beat0 replaces the outputs in the next cycle with no bubble.

Test Plan:
- SB addr 0x00001003 data 0xAABBCCDD, mem_ready=1 -> one beat next cycle: mem_addr 0x00001000, wstrb 1000, wdata 0xDD000000; busy falls the following cycle.
- SW addr 0x00002000 data 0xCAFEF00D, mem_ready low for 3 cycles -> mem_valid and outputs held constant for 4 cycles (strb 1111); req_ready=0 until the handshake cycle.
- SH addr 0x00003003 data 0x00001234, SPLIT=1:
  - beat0: 0x00003000, strb 1000, wdata 0x34000000
  - beat1: 0x00003004, strb 0001, wdata 0x00000012
- SW addr 0xFFFFFFFE data 0x11223344:
  - beat0: 0xFFFFFFFC, strb 1100, wdata 0x33440000
  - beat1: 0x00000000, strb 0011, wdata 0x00001122
  - With SPLIT=0: err pulses once, no mem_valid.
- funct3=100 at any address -> err=1 for exactly one cycle, mem_valid stays 0. Back-to-back aligned SB,SH,SW with mem_ready=1 -> 3 beats in 3 consecutive cycles.
- rst asserted while in BEAT1 with mem_ready=0 -> next cycle mem_valid=0, busy=0, req_ready=1, err=0.
